// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Owns the single regfile write port and shares it between the in-order
// writeback stage and a long-latency aux unit. Aux results wait in a small
// FIFO. A younger writeback write to the same register kills a queued aux
// entry so that the entry never reaches the regfile. A FIFO head that keeps
// losing arbitration eventually forces a one-cycle writeback stall.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_idx_i,
    input  logic [31:0] wb_data_i,
    output logic        wb_stall_o,
    input  logic        aux_valid_i,
    output logic        aux_ready_o,
    input  logic [4:0]  aux_idx_i,
    input  logic [31:0] aux_data_i,
    output logic        reg_we_o,
    output logic [4:0]  reg_idx_o,
    output logic [31:0] reg_data_o,
    output logic        pending_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    // FIFO storage and per-entry state
    logic [4:0]        idx_r  [DEPTH];
    logic [31:0]       data_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;
    logic [DEPTH-1:0]  kill_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [WAIT_W-1:0] wait_cnt_r;

    // Registered port outputs
    logic        reg_we_r;
    logic [4:0]  reg_idx_r;
    logic [31:0] reg_data_r;

    // Per-cycle decisions
    logic             head_valid_s;
    logic             head_kill_s;
    logic             starve_s;
    logic             wb_req_s;
    logic             aux_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             wr_en_s;
    logic [4:0]       wr_idx_s;
    logic [31:0]      wr_data_s;
    logic             kill_en_s;
    logic [DEPTH-1:0] kill_hit_s;
    logic [DEPTH-1:0] valid_nxt_s;
    logic [DEPTH-1:0] kill_nxt_s;

    assign head_valid_s = valid_r[rd_ptr_r];
    assign head_kill_s  = kill_r[rd_ptr_r];
    // Built purely from registers so the stall is stable for the whole cycle.
    assign starve_s     = head_valid_s & (wait_cnt_r >= MAX_WAIT_C);
    assign wb_req_s     = wb_we_i & (wb_idx_i != 5'd0);
    assign aux_ready_s  = (count_r < DEPTH_C);
    // Writes to x0 are accepted on the handshake but never stored.
    assign push_s       = aux_valid_i & aux_ready_s & (aux_idx_i != 5'd0);

    // Entries hit by a granted writeback write to the same register.
    for (genvar g = 0; g < DEPTH; g++) begin : g_kill
        assign kill_hit_s[g] = kill_en_s & valid_r[g] & (idx_r[g] == wb_idx_i);
    end

    // Write-port grant: starving head, then writeback, then any queued head.
    always_comb begin
        pop_s     = 1'b0;
        wr_en_s   = 1'b0;
        wr_idx_s  = reg_idx_r;
        wr_data_s = reg_data_r;
        kill_en_s = 1'b0;
        if (starve_s) begin
            // Head is older than the held writeback write, so it goes first.
            pop_s     = 1'b1;
            wr_en_s   = ~head_kill_s;
            wr_idx_s  = idx_r[rd_ptr_r];
            wr_data_s = data_r[rd_ptr_r];
        end else if (wb_req_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = wb_idx_i;
            wr_data_s = wb_data_i;
            kill_en_s = 1'b1;
            // A dead head needs no port, so drain it alongside.
            pop_s     = head_valid_s & head_kill_s;
        end else if (head_valid_s) begin
            pop_s     = 1'b1;
            wr_en_s   = ~head_kill_s;
            wr_idx_s  = idx_r[rd_ptr_r];
            wr_data_s = data_r[rd_ptr_r];
        end else begin
            pop_s     = 1'b0;
        end
    end

    // Next valid/kill vectors after this cycle's pop, push and WAW kills.
    always_comb begin
        valid_nxt_s = valid_r;
        kill_nxt_s  = kill_r | kill_hit_s;
        if (pop_s) begin
            valid_nxt_s[rd_ptr_r] = 1'b0;
        end else begin
            valid_nxt_s = valid_nxt_s;
        end
        if (push_s) begin
            valid_nxt_s[wr_ptr_r] = 1'b1;
            // An entry pushed in the same cycle as a same-index writeback is born dead.
            kill_nxt_s[wr_ptr_r]  = kill_en_s & (aux_idx_i == wb_idx_i);
        end else begin
            kill_nxt_s = kill_nxt_s;
        end
    end

    // FIFO payload; only ever read behind a valid bit, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            idx_r[wr_ptr_r]  <= aux_idx_i;
            data_r[wr_ptr_r] <= aux_data_i;
        end
    end

    // FIFO control state, starvation counter and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r    <= '0;
            kill_r     <= '0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            wait_cnt_r <= '0;
            reg_we_r   <= 1'b0;
            reg_idx_r  <= 5'd0;
            reg_data_r <= 32'd0;
        end else begin
            valid_r <= valid_nxt_s;
            kill_r  <= kill_nxt_s;
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (pop_s || !head_valid_s) begin
                wait_cnt_r <= '0;
            end else if (wait_cnt_r < MAX_WAIT_C) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
            reg_we_r <= wr_en_s;
            if (wr_en_s) begin
                reg_idx_r  <= wr_idx_s;
                reg_data_r <= wr_data_s;
            end
        end
    end

    assign wb_stall_o  = starve_s;
    assign aux_ready_o = aux_ready_s;
    assign reg_we_o    = reg_we_r;
    assign reg_idx_o   = reg_idx_r;
    assign reg_data_o  = reg_data_r;
    assign pending_o   = |(valid_r & ~kill_r);

endmodule
